// File: rtl/b16_bus_pkg.sv
// Shared definitions for the b16 memory bus: SRAM controller state encoding
// and bus/counter widths.
package b16_bus_pkg;

    localparam int unsigned SRAM_AW = 18;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        RECOV,
        DONE
    } bus_state_t;

endpackage

// File: rtl/sram_bus_if.sv
// CPU/debugger-side request bus into the SRAM controller: one read or
// byte-masked write request, answered by read data and a ready pulse.
interface sram_bus_if;

    logic        sel;
    logic [15:0] addr;
    logic        r;
    logic [1:0]  w;
    logic [15:0] dwrite;
    logic [15:0] rdata;
    logic        ready;

    modport master (
        output sel, addr, r, w, dwrite,
        input  rdata, ready
    );

    modport slave (
        input  sel, addr, r, w, dwrite,
        output rdata, ready
    );

endinterface

// File: rtl/sram_bus.sv
// Wait-state controller for the external 256Kx16 asynchronous SRAM: sequences
// CE/OE/WE/byte enables and the data-bus direction around a WAIT-cycle strobe.
module sram_bus
    import b16_bus_pkg::*;
#(
    parameter int unsigned WAIT = 2
) (
    input  logic               clk,
    input  logic               reset,
    sram_bus_if.slave          bus,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [15:0]        sram_dq_i,
    output logic [15:0]        sram_dq_o,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    bus_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_q, rd_d;
    logic [1:0]       mask_q, mask_d;
    logic [15:0]      rdata_q;
    logic             ready_q;
    logic             req;
    logic             capture;
    logic             active;
    logic             ce_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d, dq_oe_d, ready_d;
    logic             unused_addr0;

    assign req          = bus.sel & (bus.r | (|bus.w));
    assign bus.rdata    = rdata_q;
    assign bus.ready    = ready_q;
    assign unused_addr0 = bus.addr[0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        mask_d  = mask_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = SETUP;
                    rd_d    = bus.r;
                    mask_d  = bus.r ? 2'b11 : bus.w;
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = CNT_W'(WAIT);
            end
            STROBE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RECOV;
                    capture = rd_q;
                end
            end
            RECOV:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobes are decoded from the next state and registered, so the pins
        // change only on clock edges and carry no decode glitches.
        active  = (state_d == SETUP) || (state_d == STROBE) || (state_d == RECOV);
        ce_n_d  = !active;
        oe_n_d  = !(active && rd_d);
        we_n_d  = !((state_d == STROBE) && !rd_d);
        ub_n_d  = !(active && mask_d[1]);
        lb_n_d  = !(active && mask_d[0]);
        dq_oe_d = active && !rd_d;
        ready_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_q       <= 1'b0;
            mask_q     <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            mask_q     <= mask_d;
            ready_q    <= ready_d;
            sram_dq_oe <= dq_oe_d;
            sram_ce_n  <= ce_n_d;
            sram_oe_n  <= oe_n_d;
            sram_we_n  <= we_n_d;
            sram_ub_n  <= ub_n_d;
            sram_lb_n  <= lb_n_d;
            if (state_q == IDLE && req) begin
                sram_addr <= {{(SRAM_AW - 15){1'b0}}, bus.addr[15:1]};
                sram_dq_o <= bus.dwrite;
            end
            if (capture) begin
                rdata_q <= sram_dq_i;
            end
        end
    end

endmodule

// File: tb/tb_sram_bus.sv
// Directed bench for sram_bus: byte-lane SRAM model, per-cycle strobe tables,
// latency checks at WAIT=2 and WAIT=15, and asynchronous reset mid-write.
module tb_sram_bus;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    sram_bus_if bus ();
    sram_bus_if bus15 ();

    logic [17:0] sram_addr;
    logic [15:0] sram_dq_i, sram_dq_o;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    logic [17:0] unused15_addr;
    logic [15:0] unused15_dq_o;
    logic        unused15_dq_oe, unused15_ce_n, unused15_oe_n, unused15_we_n;
    logic        unused15_ub_n, unused15_lb_n;

    sram_bus #(.WAIT(2)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .sram_addr  (sram_addr),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_ub_n  (sram_ub_n),
        .sram_lb_n  (sram_lb_n)
    );

    sram_bus #(.WAIT(15)) u_dut15 (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus15),
        .sram_addr  (unused15_addr),
        .sram_dq_i  (16'h0F0F),
        .sram_dq_o  (unused15_dq_o),
        .sram_dq_oe (unused15_dq_oe),
        .sram_ce_n  (unused15_ce_n),
        .sram_oe_n  (unused15_oe_n),
        .sram_we_n  (unused15_we_n),
        .sram_ub_n  (unused15_ub_n),
        .sram_lb_n  (unused15_lb_n)
    );

    // SRAM model with byte lanes; poke preloads words between accesses.
    logic [15:0] mem [0:262143];
    logic        poke = 1'b0;
    logic [17:0] poke_a = '0;
    logic [15:0] poke_d = '0;

    always @(posedge clk) begin
        if (poke) begin
            mem[poke_a] <= poke_d;
        end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            if (!sram_ub_n) mem[sram_addr][15:8] <= sram_dq_o[15:8];
            if (!sram_lb_n) mem[sram_addr][7:0]  <= sram_dq_o[7:0];
        end
    end

    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0000;

    logic [6:0] strobes;
    assign strobes = {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe, bus.ready};

    logic [6:0]  obs [1:7];
    logic [17:0] addr_seen;
    logic [15:0] dqo_seen, rdata_seen;

    task automatic preload(input logic [17:0] a, input logic [15:0] d);
        @(negedge clk);
        poke = 1'b1; poke_a = a; poke_d = d;
        @(negedge clk);
        poke = 1'b0;
    endtask

    // One request held for a single edge, then strobes sampled 1ns after each edge.
    task automatic run_access(input logic r, input logic [1:0] w,
                              input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.sel = 1'b1; bus.r = r; bus.w = w; bus.addr = a; bus.dwrite = d;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            obs[k] = strobes;
            if (k == 1) begin
                addr_seen = sram_addr;
                dqo_seen  = sram_dq_o;
                bus.sel = 1'b0; bus.r = 1'b0; bus.w = 2'b00;
            end
            if (k == 5) rdata_seen = bus.rdata;
        end
    endtask

    task automatic test_reset();
        bus.sel = 1'b0; bus.r = 1'b0; bus.w = 2'b00; bus.addr = '0; bus.dwrite = '0;
        bus15.sel = 1'b0; bus15.r = 1'b0; bus15.w = 2'b00; bus15.addr = '0; bus15.dwrite = '0;
        #1 reset = 1'b1;
        #2;
        vectors++;
        if (strobes !== 7'b1111100) begin
            miscompares++;
            $display("FAIL reset_strobes got %b want %b", strobes, 7'b1111100);
        end
        vectors++;
        if (bus.rdata !== 16'h0 || sram_addr !== 18'h0 || sram_dq_o !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_regs got rdata=%h addr=%h dq_o=%h want 0/0/0",
                     bus.rdata, sram_addr, sram_dq_o);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (strobes !== 7'b1111100) begin
            miscompares++;
            $display("FAIL idle_no_req got %b want %b", strobes, 7'b1111100);
        end
    endtask

    task automatic test_read();
        logic [6:0] exp;
        preload(18'h01234, 16'hBEEF);
        run_access(1'b1, 2'b00, 16'h2468, 16'h0000);
        vectors++;
        if (addr_seen !== 18'h01234) begin
            miscompares++;
            $display("FAIL read_addr got %h want %h", addr_seen, 18'h01234);
        end
        for (int k = 1; k <= 7; k++) begin
            exp = (k <= 4) ? 7'b0010000 : (k == 5) ? 7'b1111101 : 7'b1111100;
            vectors++;
            if (obs[k] !== exp) begin
                miscompares++;
                $display("FAIL read_strobes cycle %0d got %b want %b", k, obs[k], exp);
            end
        end
        vectors++;
        if (rdata_seen !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL read_data got %h want %h", rdata_seen, 16'hBEEF);
        end
    endtask

    task automatic test_full_write();
        logic [6:0] exp;
        preload(18'h00008, 16'h0000);
        run_access(1'b0, 2'b11, 16'h0010, 16'hA55A);
        vectors++;
        if (addr_seen !== 18'h00008 || dqo_seen !== 16'hA55A) begin
            miscompares++;
            $display("FAIL wr_latch got addr=%h dq=%h want 00008/a55a", addr_seen, dqo_seen);
        end
        for (int k = 1; k <= 7; k++) begin
            exp = (k == 1 || k == 4) ? 7'b0110010 : (k <= 3) ? 7'b0100010 :
                  (k == 5) ? 7'b1111101 : 7'b1111100;
            vectors++;
            if (obs[k] !== exp) begin
                miscompares++;
                $display("FAIL wr_strobes cycle %0d got %b want %b", k, obs[k], exp);
            end
        end
        vectors++;
        if (mem[18'h00008] !== 16'hA55A) begin
            miscompares++;
            $display("FAIL wr_mem got %h want %h", mem[18'h00008], 16'hA55A);
        end
    endtask

    task automatic test_byte_write();
        logic [6:0] exp;
        preload(18'h00010, 16'hFFFF);
        run_access(1'b0, 2'b01, 16'h0020, 16'h1234);
        for (int k = 1; k <= 7; k++) begin
            exp = (k == 1 || k == 4) ? 7'b0111010 : (k <= 3) ? 7'b0101010 :
                  (k == 5) ? 7'b1111101 : 7'b1111100;
            vectors++;
            if (obs[k] !== exp) begin
                miscompares++;
                $display("FAIL bw_strobes cycle %0d got %b want %b", k, obs[k], exp);
            end
        end
        vectors++;
        if (mem[18'h00010] !== 16'hFF34) begin
            miscompares++;
            $display("FAIL bw_mem got %h want %h", mem[18'h00010], 16'hFF34);
        end
    endtask

    task automatic test_read_write();
        logic [6:0] exp;
        preload(18'h00020, 16'h5A5A);
        run_access(1'b1, 2'b11, 16'h0040, 16'hFFFF);
        for (int k = 1; k <= 7; k++) begin
            exp = (k <= 4) ? 7'b0010000 : (k == 5) ? 7'b1111101 : 7'b1111100;
            vectors++;
            if (obs[k] !== exp) begin
                miscompares++;
                $display("FAIL rw_strobes cycle %0d got %b want %b", k, obs[k], exp);
            end
        end
        vectors++;
        if (rdata_seen !== 16'h5A5A || mem[18'h00020] !== 16'h5A5A) begin
            miscompares++;
            $display("FAIL rw_data got rdata=%h mem=%h want 5a5a/5a5a", rdata_seen, mem[18'h00020]);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0, first = 0, second = 0;
        logic stray = 1'b0;
        @(negedge clk);
        bus.sel = 1'b1; bus.r = 1'b1; bus.w = 2'b00; bus.addr = 16'h2468;
        while (n < 30 && second == 0) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.ready) begin
                if (first == 0) first = n;
                else second = n;
            end
        end
        bus.sel = 1'b0;
        vectors++;
        if (first != 5 || second != 11) begin
            miscompares++;
            $display("FAIL b2b_ready got %0d,%0d want 5,11", first, second);
        end
        repeat (8) begin
            @(posedge clk);
            #1;
            if (!sram_ce_n || bus.ready) stray = 1'b1;
        end
        bus.r = 1'b0;
        vectors++;
        if (stray !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_unselected got active=%b want 0", stray);
        end
    endtask

    task automatic test_wait15();
        int n = 0, lat = 0;
        @(negedge clk);
        bus15.sel = 1'b1; bus15.r = 1'b1; bus15.addr = 16'h0100;
        while (n < 40 && lat == 0) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin bus15.sel = 1'b0; bus15.r = 1'b0; end
            if (bus15.ready) lat = n;
        end
        vectors++;
        if (lat != 18) begin
            miscompares++;
            $display("FAIL w15_latency got %0d want 18", lat);
        end
        vectors++;
        if (bus15.rdata !== 16'h0F0F) begin
            miscompares++;
            $display("FAIL w15_data got %h want %h", bus15.rdata, 16'h0F0F);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [6:0] exp;
        @(negedge clk);
        bus.sel = 1'b1; bus.r = 1'b0; bus.w = 2'b11; bus.addr = 16'h0030; bus.dwrite = 16'h1111;
        @(posedge clk);
        #1;
        bus.sel = 1'b0; bus.w = 2'b00;
        @(posedge clk);
        #1;
        vectors++;
        if (sram_we_n !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_pre_we got %b want 0", sram_we_n);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (strobes !== 7'b1111100) begin
            miscompares++;
            $display("FAIL rst_mid_strobes got %b want %b", strobes, 7'b1111100);
        end
        vectors++;
        if (bus.rdata !== 16'h0 || sram_addr !== 18'h0 || sram_dq_o !== 16'h0) begin
            miscompares++;
            $display("FAIL rst_mid_regs got rdata=%h addr=%h dq_o=%h want 0/0/0",
                     bus.rdata, sram_addr, sram_dq_o);
        end
        @(negedge clk);
        reset = 1'b0;
        run_access(1'b1, 2'b00, 16'h2468, 16'h0000);
        for (int k = 1; k <= 7; k++) begin
            exp = (k <= 4) ? 7'b0010000 : (k == 5) ? 7'b1111101 : 7'b1111100;
            vectors++;
            if (obs[k] !== exp) begin
                miscompares++;
                $display("FAIL rst_after_strobes cycle %0d got %b want %b", k, obs[k], exp);
            end
        end
        vectors++;
        if (rdata_seen !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL rst_after_data got %h want %h", rdata_seen, 16'hBEEF);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_full_write();
        test_byte_write();
        test_read_write();
        test_back_to_back();
        test_wait15();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
